// File: rtl/poly_note_player_if.sv
`default_nettype none
// ============================================================================
// Module   : poly_note_player_if
// Brief    : Control/sample bus of the polyphonic note player: note loads,
//            beat and sample-request pulses, step-ROM port, voice status and
//            mixed sample output.
// Revision : 1.0 - initial release
// ============================================================================
interface poly_note_player_if #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int PHASE_W    = 20,
    parameter int SAMPLE_W   = 16
) ();
    localparam int VOICE_W = $clog2(NUM_VOICES);

    logic                  play_enable;
    logic                  load_new_note;
    logic [VOICE_W-1:0]    load_voice;
    logic [NOTE_W-1:0]     note_to_load;
    logic [DUR_W-1:0]      duration_to_load;
    logic                  wave_to_load;
    logic                  beat;
    logic                  generate_next_sample;
    logic [NOTE_W-1:0]     step_note;
    logic [PHASE_W-1:0]    step_value;
    logic [NUM_VOICES-1:0] voice_busy;
    logic [NUM_VOICES-1:0] done_with_note;
    logic [SAMPLE_W-1:0]   sample_out;
    logic                  new_sample_ready;

    // Sequencer / codec side
    modport master (
        output play_enable, load_new_note, load_voice, note_to_load,
               duration_to_load, wave_to_load, beat, generate_next_sample,
               step_value,
        input  step_note, voice_busy, done_with_note, sample_out,
               new_sample_ready
    );

    // Player side
    modport slave (
        input  play_enable, load_new_note, load_voice, note_to_load,
               duration_to_load, wave_to_load, beat, generate_next_sample,
               step_value,
        output step_note, voice_busy, done_with_note, sample_out,
               new_sample_ready
    );
endinterface
`default_nettype wire

// File: rtl/poly_note_player.sv
`default_nettype none
// ============================================================================
// Module   : poly_note_player
// Brief    : NUM_VOICES-voice note player. Each voice keeps a note, a beat
//            countdown, a waveform select and a phase accumulator. A sample
//            request sweeps the voices one per cycle through a shared
//            note-to-step ROM port, sums their contributions and emits the
//            scaled mix with a one-cycle ready strobe.
// Revision : 1.0 - initial release
// ============================================================================
module poly_note_player #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int PHASE_W    = 20,
    parameter int SAMPLE_W   = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    poly_note_player_if.slave  bus
);
    localparam int VOICE_W = $clog2(NUM_VOICES);
    localparam int ACC_W   = SAMPLE_W + VOICE_W;

    localparam logic [SAMPLE_W-1:0] c_SQ_HIGH = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] c_SQ_LOW  = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [VOICE_W-1:0]  c_LAST    = VOICE_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t r_state, w_state_next;

    // Per-voice state
    logic [NOTE_W-1:0]  r_note      [NUM_VOICES];
    logic [DUR_W-1:0]   r_remaining [NUM_VOICES];
    logic [PHASE_W-1:0] r_phase     [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_wave;
    logic [NUM_VOICES-1:0] r_active;
    logic [NUM_VOICES-1:0] r_done;

    // Sweep datapath
    logic [VOICE_W-1:0]   r_idx;
    logic signed [ACC_W-1:0] r_acc;
    logic [SAMPLE_W-1:0]  r_sample_out;

    logic [NUM_VOICES-1:0] w_load;
    logic [NUM_VOICES-1:0] w_hit;
    logic [NUM_VOICES-1:0] w_tick;
    logic                  w_start;
    logic [PHASE_W-1:0]    w_sel_phase;
    logic [SAMPLE_W-1:0]   w_top;
    logic [SAMPLE_W-1:0]   w_contrib;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [ACC_W-1:0] w_acc_shr;

    assign w_start = bus.generate_next_sample && bus.play_enable;

    // Per-voice event decode: load target, voice under sweep, beat tick
    always_comb begin
        w_load = '0;
        w_hit  = '0;
        w_tick = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_load[v] = bus.load_new_note && (bus.load_voice == VOICE_W'(v));
            w_hit[v]  = (r_state == S_SWEEP) && (r_idx == VOICE_W'(v)) && r_active[v];
            w_tick[v] = bus.beat && bus.play_enable && r_active[v];
        end
    end

    // Contribution of the voice under sweep, from its pre-increment phase
    always_comb begin
        w_sel_phase = r_phase[r_idx];
        w_top       = w_sel_phase[PHASE_W-1 -: SAMPLE_W];
        w_contrib   = '0;
        if (r_active[r_idx]) begin
            if (r_wave[r_idx])
                w_contrib = w_sel_phase[PHASE_W-1] ? c_SQ_LOW : c_SQ_HIGH;
            else
                w_contrib = {~w_top[SAMPLE_W-1], w_top[SAMPLE_W-2:0]};
        end
        w_acc_next = r_acc + $signed({{VOICE_W{w_contrib[SAMPLE_W-1]}}, w_contrib});
        w_acc_shr  = w_acc_next >>> VOICE_W;
    end

    // Voice state: a load beats both the phase step and the beat countdown
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_note[v]      <= '0;
                r_remaining[v] <= '0;
                r_phase[v]     <= '0;
            end
            r_wave   <= '0;
            r_active <= '0;
            r_done   <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_done[v] <= 1'b0;
                if (w_load[v]) begin
                    r_note[v]      <= bus.note_to_load;
                    r_remaining[v] <= bus.duration_to_load;
                    r_wave[v]      <= bus.wave_to_load;
                    r_phase[v]     <= '0;
                    r_active[v]    <= (bus.duration_to_load != '0);
                end else begin
                    if (w_hit[v])
                        r_phase[v] <= r_phase[v] + bus.step_value;
                    if (w_tick[v]) begin
                        r_remaining[v] <= r_remaining[v] - DUR_W'(1);
                        if (r_remaining[v] == DUR_W'(1)) begin
                            r_active[v] <= 1'b0;
                            r_done[v]   <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Sample FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Sample FSM next state and outputs
    always_comb begin
        w_state_next         = r_state;
        bus.new_sample_ready = 1'b0;
        bus.step_note        = r_note[0];
        case (r_state)
            S_IDLE: begin
                if (w_start)
                    w_state_next = S_SWEEP;
            end
            S_SWEEP: begin
                bus.step_note = r_note[r_idx];
                if (r_idx == c_LAST)
                    w_state_next = S_OUT;
            end
            S_OUT: begin
                bus.new_sample_ready = 1'b1;
                w_state_next         = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Sweep index, accumulator and held output sample; the sample register
    // is loaded on the edge entering OUT so it changes with the ready strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx        <= '0;
            r_acc        <= '0;
            r_sample_out <= '0;
        end else begin
            if (r_state == S_IDLE && w_start) begin
                r_idx <= '0;
                r_acc <= '0;
            end else if (r_state == S_SWEEP) begin
                r_idx <= r_idx + VOICE_W'(1);
                r_acc <= w_acc_next;
                if (r_idx == c_LAST)
                    r_sample_out <= w_acc_shr[SAMPLE_W-1:0];
            end
        end
    end

    assign bus.voice_busy     = r_active;
    assign bus.done_with_note = r_done;
    assign bus.sample_out     = r_sample_out;

endmodule
`default_nettype wire

// File: tb/tb_poly_note_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_note_player
// Brief    : Directed self-checking bench for poly_note_player with a
//            note*4096 step-ROM stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_poly_note_player;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    poly_note_player_if bus ();

    poly_note_player dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Step ROM stub: step = note * 4096
    assign bus.step_value = 20'({bus.step_note, 12'h000});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_load(input int v, input int note, input int dur, input logic wave,
                           input logic with_beat);
        @(negedge clk);
        bus.load_new_note    = 1'b1;
        bus.load_voice       = 2'(v);
        bus.note_to_load     = 6'(note);
        bus.duration_to_load = 6'(dur);
        bus.wave_to_load     = wave;
        bus.beat             = with_beat;
        @(negedge clk);
        bus.load_new_note    = 1'b0;
        bus.beat             = 1'b0;
    endtask

    task automatic do_beat();
        @(negedge clk);
        bus.beat = 1'b1;
        @(negedge clk);
        bus.beat = 1'b0;
    endtask

    // Issue one request, return the sample and latency (-1 on timeout)
    task automatic do_req(output logic [15:0] s, output int lat);
        @(negedge clk);
        bus.generate_next_sample = 1'b1;
        @(negedge clk);
        bus.generate_next_sample = 1'b0;
        lat = -1;
        s   = 16'hxxxx;
        for (int k = 1; k <= 20; k++) begin
            if (bus.new_sample_ready) begin
                lat = k;
                s   = bus.sample_out;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        chk("ready_one_cycle", 32'(bus.new_sample_ready), 32'd0);
    endtask

    logic [15:0] smp;
    int          lat;
    int          strobes;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.play_enable          = 1'b0;
        bus.load_new_note        = 1'b0;
        bus.load_voice           = '0;
        bus.note_to_load         = '0;
        bus.duration_to_load     = '0;
        bus.wave_to_load         = 1'b0;
        bus.beat                 = 1'b0;
        bus.generate_next_sample = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_sample", 32'(bus.sample_out), 32'h0);
        chk("rst_ready",  32'(bus.new_sample_ready), 32'h0);
        chk("rst_busy",   32'(bus.voice_busy), 32'h0);
        chk("rst_done",   32'(bus.done_with_note), 32'h0);

        // Saw sweep
        bus.play_enable = 1'b1;
        do_load(0, 10, 3, 1'b0, 1'b0);
        chk("load_busy", 32'(bus.voice_busy), 32'h1);
        do_req(smp, lat);
        chk("saw1_sample", 32'(smp), 32'hE000);
        chk("saw1_latency", 32'(lat), 32'd5);
        do_req(smp, lat);
        chk("saw2_sample", 32'(smp), 32'hE280);
        chk("saw_held", 32'(bus.sample_out), 32'hE280);

        // Duration countdown
        do_beat();
        do_beat();
        chk("dur_busy_b2", 32'(bus.voice_busy), 32'h1);
        chk("dur_done_b2", 32'(bus.done_with_note), 32'h0);
        do_beat();
        chk("dur_done_b3", 32'(bus.done_with_note), 32'h1);
        chk("dur_busy_b3", 32'(bus.voice_busy), 32'h0);
        @(negedge clk);
        chk("dur_done_pulse", 32'(bus.done_with_note), 32'h0);
        do_req(smp, lat);
        chk("dur_silent", 32'(smp), 32'h0000);

        // Mix of four square voices
        for (int v = 0; v < 4; v++) do_load(v, 0, 5, 1'b1, 1'b0);
        chk("mix_busy", 32'(bus.voice_busy), 32'hF);
        do_req(smp, lat);
        chk("mix4_sample", 32'(smp), 32'h7FFF);
        do_load(2, 0, 0, 1'b1, 1'b0);
        chk("kill2_done", 32'(bus.done_with_note), 32'h0);
        do_load(3, 0, 0, 1'b1, 1'b0);
        chk("kill3_done", 32'(bus.done_with_note), 32'h0);
        chk("kill_busy", 32'(bus.voice_busy), 32'h3);
        do_req(smp, lat);
        chk("mix2_sample", 32'(smp), 32'h3FFF);

        // Gating: beats and requests ignored while disabled
        bus.play_enable = 1'b0;
        repeat (5) do_beat();
        chk("gate_busy", 32'(bus.voice_busy), 32'h3);
        chk("gate_done", 32'(bus.done_with_note), 32'h0);
        @(negedge clk);
        bus.generate_next_sample = 1'b1;
        @(negedge clk);
        bus.generate_next_sample = 1'b0;
        strobes = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.new_sample_ready) strobes++;
            @(negedge clk);
        end
        chk("gate_no_ready", 32'(strobes), 32'd0);
        chk("gate_hold", 32'(bus.sample_out), 32'h3FFF);
        bus.play_enable = 1'b1;
        do_req(smp, lat);
        chk("reen_sample", 32'(smp), 32'h3FFF);
        chk("reen_latency", 32'(lat), 32'd5);
        repeat (4) do_beat();
        chk("reen_busy_b4", 32'(bus.voice_busy), 32'h3);
        do_beat();
        chk("reen_done_b5", 32'(bus.done_with_note), 32'h3);
        chk("reen_busy_b5", 32'(bus.voice_busy), 32'h0);

        // Collision: load and beat on the same voice in one cycle
        do_load(1, 0, 1, 1'b1, 1'b0);
        do_load(1, 0, 2, 1'b1, 1'b1);
        chk("coll_done", 32'(bus.done_with_note), 32'h0);
        chk("coll_busy", 32'(bus.voice_busy), 32'h2);
        do_beat();
        chk("coll_b1_done", 32'(bus.done_with_note), 32'h0);
        chk("coll_b1_busy", 32'(bus.voice_busy), 32'h2);
        do_beat();
        chk("coll_b2_done", 32'(bus.done_with_note), 32'h2);

        // Collision: request during sweep is dropped
        @(negedge clk);
        bus.generate_next_sample = 1'b1;
        @(negedge clk);
        bus.generate_next_sample = 1'b0;
        @(negedge clk);
        bus.generate_next_sample = 1'b1;
        @(negedge clk);
        bus.generate_next_sample = 1'b0;
        strobes = 0;
        for (int k = 0; k < 15; k++) begin
            if (bus.new_sample_ready) strobes++;
            @(negedge clk);
        end
        chk("sweep_req_strobes", 32'(strobes), 32'd1);

        // Reset in the middle of a sweep
        do_load(0, 10, 5, 1'b0, 1'b0);
        do_req(smp, lat);
        chk("pre_rst_sample", 32'(smp), 32'hE000);
        @(negedge clk);
        bus.generate_next_sample = 1'b1;
        @(negedge clk);
        bus.generate_next_sample = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_sample", 32'(bus.sample_out), 32'h0);
        chk("mid_rst_busy",   32'(bus.voice_busy), 32'h0);
        strobes = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.new_sample_ready) strobes++;
            @(negedge clk);
        end
        chk("mid_rst_idle", 32'(strobes), 32'd0);
        do_load(0, 10, 5, 1'b0, 1'b0);
        do_req(smp, lat);
        chk("post_rst_sample", 32'(smp), 32'hE000);
        chk("post_rst_latency", 32'(lat), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/poly_note_player.md
# poly_note_player

Multi-voice successor to the single-voice note player. Holds `NUM_VOICES` independent notes, each with its own beat-counted duration, waveform mode and phase accumulator. On each sample request it sweeps all voices through one shared note-to-step lookup port, mixes the active voices into one signed sample and raises a one-cycle ready strobe. It sits between the song reader/chord sequencer (note loads) and the codec sample path, driven by the shared beat generator.

## Interface
- `NUM_VOICES`, 4: voice count; power of two, ≥2. `VOICE_W = $clog2(NUM_VOICES)`.
- `NOTE_W`, 6: note number width.
- `DUR_W`, 6: duration width, in beats.
- `PHASE_W`, 20: phase accumulator and step width.
- `SAMPLE_W`, 16: output sample width, two's complement; `SAMPLE_W ≤ PHASE_W`.
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `play_enable` in 1: when low, beats and sample requests are ignored.
- `load_new_note` in 1: single-cycle load strobe.
- `load_voice` in VOICE_W: target voice of the load.
- `note_to_load` in NOTE_W: note number.
- `duration_to_load` in DUR_W: length in beats.
- `wave_to_load` in 1: waveform, 0 = sawtooth, 1 = square.
- `beat` in 1: one-cycle pulse from the beat generator.
- `generate_next_sample` in 1: sample request pulse.
- `step_note` out NOTE_W: note number presented to the external frequency ROM.
- `step_value` in PHASE_W: combinational ROM result for `step_note`, used in the same cycle.
- `voice_busy` out NUM_VOICES: per-voice active flag.
- `done_with_note` out NUM_VOICES: per-voice one-cycle pulse when a note expires.
- `sample_out` out SAMPLE_W: mixed sample, held between updates.
- `new_sample_ready` out 1: one-cycle strobe marking a new `sample_out`.

## Operation
- Per-voice state: `note`, `remaining` (DUR_W), `wave`, `phase` (PHASE_W), `active`.
- **Load** (`load_new_note`, independent of `play_enable`):
  - If `duration_to_load != 0`: voice `load_voice` takes the note, duration and wave; its phase is cleared to 0; it becomes active. A load on a busy voice retriggers it, with no done pulse.
  - If `duration_to_load == 0`: the voice is deactivated, with no done pulse.
- **Beat** (`beat && play_enable`): every active voice decrements `remaining`. A voice reaching 0 clears `active` and pulses its `done_with_note` bit.
  - If a load and a beat hit the same voice in the same cycle, the load wins; no decrement.
- **Sample FSM**, states IDLE, SWEEP, OUT:
  - IDLE → SWEEP on `generate_next_sample && play_enable`. Voice index = 0, accumulator = 0.
  - SWEEP, voice i:
    - `step_note` = note[i].
    - If active: contribution is computed from the pre-increment phase, then `phase[i] += step_value`, wrapping mod 2^PHASE_W. Inactive voices contribute 0 and keep their phase.
    - After voice NUM_VOICES-1 → OUT.
  - OUT: `sample_out` = accumulator >>> VOICE_W (arithmetic shift); `new_sample_ready` = 1; → IDLE.
- Contribution widths:
  - Let `top = phase[PHASE_W-1 -: SAMPLE_W]`.
  - Saw = `{~top[MSB], top[MSB-1:0]}` as signed.
  - Square = 0x7FFF-equivalent (max positive) when phase MSB = 0, 0x8000-equivalent (min negative) when MSB = 1.
  - Accumulator is SAMPLE_W+VOICE_W bits signed; it never overflows.
- Sample requests arriving outside IDLE are dropped. `play_enable` falling mid-sweep does not abort the sweep.
- A load to voice i during SWEEP takes effect immediately. If voice i is being swept that cycle, the load's phase clear wins over the increment. A contribution already accumulated is kept.
- `step_note` outside SWEEP = note[0].

## Timing
- Reset values: `sample_out` = 0, `new_sample_ready` = 0, `voice_busy` = 0, `done_with_note` = 0, all phases/counters = 0, FSM = IDLE.
- Load registers on the load edge; `voice_busy` rises on the next cycle.
- `done_with_note` and the `voice_busy` fall are registered: both appear the cycle after the expiring beat.
- Request-to-ready latency is NUM_VOICES+1 cycles, counted from the request edge to the `new_sample_ready` high cycle. Minimum request spacing is NUM_VOICES+2 cycles.
- `sample_out` changes only in the cycle `new_sample_ready` is high.

## Test plan
- **Reset** mid-sweep (assert for 2 cycles) → all outputs 0, FSM IDLE; next request produces a sample normally.
- **Saw sweep**. Stub `step_value = step_note*4096`. Load voice 0, note 10, duration 3, saw.
  - First request → `sample_out` 0xE000 after 5 cycles.
  - Second request → 0xE280.
- **Duration**: same load, 3 beats with `play_enable` = 1 → `done_with_note` = 4'b0001 for one cycle after the 3rd beat, `voice_busy[0]` falls. Next sample = 0x0000.
- **Mix**: all 4 voices, note 0, square → phase stays 0, `sample_out` = 0x7FFF. Deactivate 2 voices via duration 0 → 0x3FFF, with no done pulses.
- **Gating**: `play_enable` = 0 while sending beats and requests → no decrement, no `new_sample_ready`, `sample_out` holds. Re-enable → resumes.
- **Collisions**:
  - Load voice 1 in the same cycle as a beat → `remaining` = loaded value, no done pulse.
  - Request during SWEEP → ignored; exactly one ready strobe.
